bip_control_unit: RTL and testbench

- Multi-cycle control unit that sequences the accumulator datapath (SelA/SelB/WrAcc/Op/Clear) for the 16-bit accumulator ISA.
- Fetches instructions from program memory, decodes the opcode, and drives data-memory read/write strobes.
- Exposes run/halt status and an execution cycle counter.
- Sits beside the datapath in the processor top; Operand drives the datapath Addr input and the data-memory address.

---
 rtl/bip_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_bip_control_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// bip_control_unit
// Multi-cycle sequencer for the 16-bit accumulator ISA. Fetches an
// instruction from program memory, decodes the 5-bit opcode and drives the
// accumulator datapath selects plus the data-memory strobes.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   Start         one-cycle run request (honoured in IDLE/HALT only)
//   Instr         instruction word read combinationally from Prog_Addr
//   Prog_Addr     program counter
//   Operand       IR[AB-1:0], datapath Addr / data-memory address
//   Rd, Wr        data-memory read / write strobes
//   SelA, SelB    accumulator source / ALU operand-B selects
//   WrAcc, Op     accumulator write enable, ALU op (1 add, 0 subtract)
//   Clear         accumulator clear pulse on an accepted Start
//   Busy, Halted  run status
//   Cycle_Count   saturating count of busy cycles since the last Start
module bip_control_unit #(
  parameter int PB = 11,
  parameter int AB = 11,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [IW-1:0] Instr,
  output logic [PB-1:0] Prog_Addr,
  output logic [AB-1:0] Operand,
  output logic          Rd,
  output logic          Wr,
  output logic [1:0]    SelA,
  output logic          SelB,
  output logic          WrAcc,
  output logic          Op,
  output logic          Clear,
  output logic          Busy,
  output logic          Halted,
  output logic [15:0]   Cycle_Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_t;

  state_t        state_q, state_d;
  logic [PB-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [4:0]    opc;
  logic [PB-1:0] pc_inc;

  assign opc         = ir_q[IW-1:IW-5];
  assign pc_inc      = pc_q + PB'(1);  // wraps naturally at 2^PB
  assign Prog_Addr   = pc_q;
  assign Operand     = ir_q[AB-1:0];
  assign Cycle_Count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    Rd      = 1'b0;
    Wr      = 1'b0;
    SelA    = 2'd0;
    SelB    = 1'b0;
    WrAcc   = 1'b0;
    Op      = 1'b0;
    Clear   = 1'b0;
    Busy    = 1'b0;
    Halted  = 1'b0;

    // Counter saturates rather than wrapping.
    if (state_q inside {S_FETCH, S_EXEC, S_MEM}) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        Halted = (state_q == S_HALT);
        if (Start) begin
          Clear   = 1'b1;
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        Busy    = 1'b1;
        ir_d    = Instr;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        Busy    = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (opc)
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          OP_STO: Wr = 1'b1;
          OP_LDI: begin
            SelA  = 2'd1;
            WrAcc = 1'b1;
          end
          OP_ADDI: begin
            Op    = 1'b1;
            WrAcc = 1'b1;
          end
          OP_SUBI: WrAcc = 1'b1;
          OP_LD, OP_ADD, OP_SUB: begin
            // Synchronous data memory: result consumed in MEM.
            Rd      = 1'b1;
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          default: ;  // NOP
        endcase
      end

      S_MEM: begin
        Busy    = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (opc)
          OP_LD: begin
            SelA  = 2'd2;
            WrAcc = 1'b1;
          end
          OP_ADD: begin
            SelB  = 1'b1;
            Op    = 1'b1;
            WrAcc = 1'b1;
          end
          OP_SUB: begin
            SelB  = 1'b1;
            WrAcc = 1'b1;
          end
          default: ;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;

  // Control vector bit positions: {Rd,Wr,SelA[1:0],SelB,WrAcc,Op,Clear,Busy,Halted}
  localparam logic [9:0] C_RD   = 10'b10_0000_0000;
  localparam logic [9:0] C_WR   = 10'b01_0000_0000;
  localparam logic [9:0] C_SA1  = 10'b00_0100_0000;
  localparam logic [9:0] C_SA2  = 10'b00_1000_0000;
  localparam logic [9:0] C_SB   = 10'b00_0010_0000;
  localparam logic [9:0] C_WA   = 10'b00_0001_0000;
  localparam logic [9:0] C_OP   = 10'b00_0000_1000;
  localparam logic [9:0] C_CLR  = 10'b00_0000_0100;
  localparam logic [9:0] C_BSY  = 10'b00_0000_0010;
  localparam logic [9:0] C_HLT  = 10'b00_0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, Start;
  logic [15:0] Instr;
  logic [10:0] Prog_Addr, Operand;
  logic        Rd, Wr, SelB, WrAcc, Op, Clear, Busy, Halted;
  logic [1:0]  SelA;
  logic [15:0] Cycle_Count;
  logic [15:0] prog [0:2047];

  assign Instr = prog[Prog_Addr];

  bip_control_unit #(.PB(11), .AB(11), .IW(16)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Instr(Instr),
    .Prog_Addr(Prog_Addr), .Operand(Operand), .Rd(Rd), .Wr(Wr),
    .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op), .Clear(Clear),
    .Busy(Busy), .Halted(Halted), .Cycle_Count(Cycle_Count)
  );

  // Second instance: 2-bit PC running a looped NOP program forever.
  logic        rst2, Start2;
  logic [1:0]  Prog_Addr2;
  logic [10:0] Operand2;
  logic        Rd2, Wr2, SelB2, WrAcc2, Op2, Clear2, Busy2, Halted2;
  logic [1:0]  SelA2;
  logic [15:0] Cycle_Count2;
  logic        done2 = 1'b0;

  bip_control_unit #(.PB(2), .AB(11), .IW(16)) dut2 (
    .clk(clk), .rst(rst2), .Start(Start2), .Instr(16'h4000),
    .Prog_Addr(Prog_Addr2), .Operand(Operand2), .Rd(Rd2), .Wr(Wr2),
    .SelA(SelA2), .SelB(SelB2), .WrAcc(WrAcc2), .Op(Op2), .Clear(Clear2),
    .Busy(Busy2), .Halted(Halted2), .Cycle_Count(Cycle_Count2)
  );

  logic [9:0] obs, obs2;
  assign obs  = {Rd, Wr, SelA, SelB, WrAcc, Op, Clear, Busy, Halted};
  assign obs2 = {Rd2, Wr2, SelA2, SelB2, WrAcc2, Op2, Clear2, Busy2, Halted2};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction-level view of the machine.
  int m_pc, m_cnt;
  bit m_halt;

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  // Expected controls for an instruction's EXEC and (optional) MEM cycle.
  function automatic void decode(input logic [4:0] opc, output logic [9:0] ex,
                                 output logic [9:0] mm, output bit mem, output bit hlt);
    mem = 0; hlt = 0; ex = C_BSY; mm = C_BSY;
    case (opc)
      5'd0: hlt = 1;
      5'd1: ex = C_BSY | C_WR;
      5'd2: begin ex = C_BSY | C_RD; mem = 1; mm = C_BSY | C_SA2 | C_WA; end
      5'd3: ex = C_BSY | C_SA1 | C_WA;
      5'd4: begin ex = C_BSY | C_RD; mem = 1; mm = C_BSY | C_SB | C_WA | C_OP; end
      5'd5: ex = C_BSY | C_OP | C_WA;
      5'd6: begin ex = C_BSY | C_RD; mem = 1; mm = C_BSY | C_SB | C_WA; end
      5'd7: ex = C_BSY | C_WA;
      default: ;
    endcase
  endfunction

  task automatic cyc(input logic st);
    @(negedge clk);
    Start = st;
    #1;
  endtask

  task automatic noise_start(input bit noise);
    cyc(noise ? logic'($urandom_range(0, 2) == 0) : 1'b0);
  endtask

  // Pulse Start from IDLE/HALT and step the program until HLT or max_instr.
  task automatic run_prog(input int max_instr, input bit noise);
    logic [15:0] ir;
    logic [9:0]  ex, mm;
    bit          mem, hlt;
    cyc(1'b1);
    check("start_ctl", 32'(obs), 32'(m_halt ? (C_CLR | C_HLT) : C_CLR));
    m_pc = 0; m_cnt = 0; m_halt = 0;
    for (int i = 0; i < max_instr; i++) begin
      noise_start(noise);
      check("fetch_ctl", 32'(obs), 32'(C_BSY));
      check("fetch_pc", 32'(Prog_Addr), m_pc);
      check("fetch_cnt", 32'(Cycle_Count), m_cnt);
      ir = prog[m_pc];
      m_cnt = sat(m_cnt);
      decode(ir[15:11], ex, mm, mem, hlt);
      noise_start(noise);
      check("exec_ctl", 32'(obs), 32'(ex));
      check("exec_opnd", 32'(Operand), 32'(ir[10:0]));
      check("exec_cnt", 32'(Cycle_Count), m_cnt);
      m_cnt = sat(m_cnt);
      if (hlt) begin
        m_halt = 1;
        break;
      end
      if (mem) begin
        noise_start(noise);
        check("mem_ctl", 32'(obs), 32'(mm));
        check("mem_opnd", 32'(Operand), 32'(ir[10:0]));
        m_cnt = sat(m_cnt);
      end
      m_pc = (m_pc + 1) % 2048;
    end
    if (m_halt) begin
      cyc(1'b0);
      check("halt_ctl", 32'(obs), 32'(C_HLT));
      check("halt_pc", 32'(Prog_Addr), m_pc);
      check("halt_cnt", 32'(Cycle_Count), m_cnt);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0;
    clear_prog();
    m_pc = 0; m_cnt = 0; m_halt = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 32'(obs), 32'(0));
    check("reset_pc", 32'(Prog_Addr), 0);
    check("reset_cnt", 32'(Cycle_Count), 0);
    rst = 1'b0;
    cyc(1'b0);
    check("idle_ctl", 32'(obs), 32'(0));

    // LDI/ADDI/STO/HLT
    prog[0] = 16'h1805; prog[1] = 16'h2803; prog[2] = 16'h080A; prog[3] = 16'h0000;
    run_prog(8, 0);
    check("p1_halted", 32'(Halted), 1);
    check("p1_pc", 32'(Prog_Addr), 3);
    check("p1_cnt", 32'(Cycle_Count), 8);

    // LD/ADD/SUB/HLT, restarted from HALT
    prog[0] = 16'h100A; prog[1] = 16'h200B; prog[2] = 16'h300C; prog[3] = 16'h0000;
    run_prog(8, 0);
    check("p2_pc", 32'(Prog_Addr), 3);
    check("p2_cnt", 32'(Cycle_Count), 11);

    // Reset while an LD sits in MEM
    clear_prog();
    prog[0] = 16'h4000; prog[1] = 16'h100A;
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check("rld_exec", 32'(obs), 32'(C_BSY | C_RD));
    cyc(1'b0);
    check("rld_mem", 32'(obs), 32'(C_BSY | C_SA2 | C_WA));
    rst = 1'b1;
    #1;
    check("rld_async_ctl", 32'(obs), 32'(0));
    check("rld_async_pc", 32'(Prog_Addr), 0);
    check("rld_async_cnt", 32'(Cycle_Count), 0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_cnt = 0; m_halt = 0;
    #1;
    check("rld_idle_ctl", 32'(obs), 32'(0));

    // NOP then SUBI, from IDLE
    prog[0] = 16'h4000; prog[1] = 16'h3807; prog[2] = 16'h0000;
    run_prog(8, 0);
    check("p3_cnt", 32'(Cycle_Count), 6);

    // Random programs with stray Start pulses while busy
    for (int t = 0; t < 40; t++) begin
      int len;
      clear_prog();
      len = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        logic [4:0] opc;
        opc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
        prog[k] = {opc, 11'($urandom)};
      end
      prog[len] = 16'h0000;
      run_prog(len + 1, 1);
    end

    for (int k = 0; k < 70000 && !done2; k++) @(negedge clk);
    check("dut2_done", 32'(done2), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // PB=2 instance: PC wrap and counter saturation.
  initial begin
    rst2 = 1'b1; Start2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    Start2 = 1'b1;
    #1;
    check("d2_start_ctl", 32'(obs2), 32'(C_CLR));
    @(negedge clk);
    Start2 = 1'b0;
    #1;
    // c counts busy cycles since the accepted Start; each NOP is 2 cycles.
    for (int c = 0; c < 65546; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (c < 20) begin
        check("d2_ctl", 32'(obs2), 32'(C_BSY));
        check("d2_pc", 32'(Prog_Addr2), (c / 2) % 4);
        check("d2_cnt", 32'(Cycle_Count2), c);
      end
      if (c == 65534) check("d2_cnt_fffe", 32'(Cycle_Count2), 32'hFFFE);
      if (c == 65535) check("d2_cnt_ffff", 32'(Cycle_Count2), 32'hFFFF);
      if (c == 65536) check("d2_cnt_sat", 32'(Cycle_Count2), 32'hFFFF);
      if (c == 65545) check("d2_cnt_hold", 32'(Cycle_Count2), 32'hFFFF);
    end
    done2 = 1'b1;
  end

endmodule
